// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: supported polynomial pairs, checker state encoding,
// and reference helpers for popcount and a W-step LFSR advance.
package prbs_pkg;

  localparam int MAX_W = 1024;
  localparam int MAX_N = 31;

  localparam int PRBS7_N  = 7;   localparam int PRBS7_TAP  = 6;
  localparam int PRBS9_N  = 9;   localparam int PRBS9_TAP  = 5;
  localparam int PRBS15_N = 15;  localparam int PRBS15_TAP = 14;
  localparam int PRBS23_N = 23;  localparam int PRBS23_TAP = 18;
  localparam int PRBS31_N = 31;  localparam int PRBS31_TAP = 28;

  typedef enum logic {SEARCH, LOCKED} state_e;

  function automatic logic [31:0] popcount(input logic [MAX_W-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Returns {E, S_next}; E occupies the upper MAX_W bits with E[w-1] produced first.
  function automatic logic [MAX_W+MAX_N-1:0] prbs_adv(input logic [MAX_N-1:0] s,
                                                      input int n, input int tap,
                                                      input int inv, input int w);
    logic [MAX_W-1:0] e;
    logic             b;
    e = '0;
    for (int i = 0; i < w; i++) begin
      b = s[n-1] ^ s[tap-1] ^ inv[0];
      e[w-1-i] = b;
      s = {s[MAX_N-2:0], b};
    end
    return {e, s & ((MAX_N'(1) << n) - MAX_N'(1))};
  endfunction

endpackage

// File: rtl/prbs_adv_par.sv
// Combinational W-step advance of an x^N + x^TAP + 1 LFSR: produces the next W
// line bits (oldest in MSB) and the state left behind after those W steps.
module prbs_adv_par #(
  parameter int W      = 64,
  parameter int N      = 31,
  parameter int TAP    = 28,
  parameter int INVERT = 1
) (
  input  logic [N-1:0] s_i,
  output logic [W-1:0] e_o,
  output logic [N-1:0] s_next_o
);

  localparam logic INV_B = (INVERT != 0);

  logic [N-1:0] st [0:W];

  assign st[0]    = s_i;
  assign s_next_o = st[W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_step
      logic fb;
      assign fb           = st[gi][N-1] ^ st[gi][TAP-1] ^ INV_B;
      assign e_o[W-1-gi]  = fb;
      assign st[gi+1]     = {st[gi][N-2:0], fb};
    end
  endgenerate

endmodule

// File: rtl/prbs_chk_lock_param.sv
// Self-synchronising parallel PRBS checker: seeds from received data while searching,
// free-runs once locked, and keeps saturating error statistics.
module prbs_chk_lock_param
  import prbs_pkg::*;
#(
  parameter int W          = 64,
  parameter int PRBS_N     = 31,
  parameter int PRBS_TAP   = 28,
  parameter int INVERT     = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 48
) (
  input  logic                     C,
  input  logic                     R,
  input  logic                     CE,
  input  logic [W-1:0]             D,
  input  logic                     clr_cnt,
  output logic                     locked,
  output logic                     lol,
  output logic                     err_word,
  output logic [$clog2(W+1)-1:0]   err_bits,
  output logic [CNT_W-1:0]         err_word_cnt,
  output logic [CNT_W-1:0]         err_bit_cnt,
  output logic [CNT_W-1:0]         word_cnt
);

  localparam int EB_W = $clog2(W+1);
  localparam int MC_W = $clog2(LOCK_CNT+1);
  localparam int UC_W = $clog2(UNLOCK_CNT+1);
  localparam logic [PRBS_N-1:0] DEGEN = (INVERT != 0) ? {PRBS_N{1'b1}} : {PRBS_N{1'b0}};

  generate
    if (W < PRBS_N) begin : g_w_chk
      $error("prbs_chk_lock_param: W must be >= PRBS_N");
    end
    if (PRBS_TAP < 1 || PRBS_TAP >= PRBS_N) begin : g_tap_chk
      $error("prbs_chk_lock_param: PRBS_TAP must satisfy 1 <= PRBS_TAP < PRBS_N");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [PRBS_N-1:0]   s_q, s_d;
  logic [MC_W-1:0]     match_q, match_d;
  logic [UC_W-1:0]     miss_q, miss_d;
  logic                lol_q, lol_d;
  logic                err_word_q, err_word_d;
  logic [EB_W-1:0]     err_bits_q, err_bits_d;
  logic [CNT_W-1:0]    err_word_cnt_q, err_word_cnt_d;
  logic [CNT_W-1:0]    err_bit_cnt_q, err_bit_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;

  logic [W-1:0]        e_w;
  logic [PRBS_N-1:0]   s_adv;
  logic [W-1:0]        mism;
  logic [EB_W-1:0]     pop;

  prbs_adv_par #(
    .W      (W),
    .N      (PRBS_N),
    .TAP    (PRBS_TAP),
    .INVERT (INVERT)
  ) u_adv (
    .s_i      (s_q),
    .e_o      (e_w),
    .s_next_o (s_adv)
  );

  assign mism = D ^ e_w;
  assign pop  = EB_W'(popcount(MAX_W'(mism)));

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    s_d            = s_q;
    match_d        = match_q;
    miss_d         = miss_q;
    lol_d          = 1'b0;
    err_word_d     = 1'b0;
    err_bits_d     = '0;
    err_word_cnt_d = err_word_cnt_q;
    err_bit_cnt_d  = err_bit_cnt_q;
    word_cnt_d     = word_cnt_q;

    if (CE) begin
      case (state_q)
        SEARCH: begin
          s_d = D[PRBS_N-1:0];
          // A degenerate seed predicts itself forever, so it must never count as a match.
          if (D == e_w && s_q != DEGEN) match_d = match_q + 1'b1;
          else                          match_d = '0;
          if (match_d == MC_W'(LOCK_CNT)) begin
            state_d = LOCKED;
            match_d = '0;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          s_d            = s_adv;
          err_word_d     = |mism;
          err_bits_d     = pop;
          word_cnt_d     = sat_add(word_cnt_q, CNT_W'(1));
          err_bit_cnt_d  = sat_add(err_bit_cnt_q, CNT_W'(pop));
          err_word_cnt_d = sat_add(err_word_cnt_q, CNT_W'(|mism));
          miss_d         = (|mism) ? miss_q + 1'b1 : '0;
          if (miss_d == UC_W'(UNLOCK_CNT)) begin
            state_d = SEARCH;
            lol_d   = 1'b1;
            match_d = '0;
            miss_d  = '0;
            s_d     = D[PRBS_N-1:0];
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr_cnt) begin
      err_word_cnt_d = '0;
      err_bit_cnt_d  = '0;
      word_cnt_d     = '0;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q        <= SEARCH;
      s_q            <= {PRBS_N{1'b1}};
      match_q        <= '0;
      miss_q         <= '0;
      lol_q          <= 1'b0;
      err_word_q     <= 1'b0;
      err_bits_q     <= '0;
      err_word_cnt_q <= '0;
      err_bit_cnt_q  <= '0;
      word_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      match_q        <= match_d;
      miss_q         <= miss_d;
      lol_q          <= lol_d;
      err_word_q     <= err_word_d;
      err_bits_q     <= err_bits_d;
      err_word_cnt_q <= err_word_cnt_d;
      err_bit_cnt_q  <= err_bit_cnt_d;
      word_cnt_q     <= word_cnt_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign lol          = lol_q;
  assign err_word     = err_word_q;
  assign err_bits     = err_bits_q;
  assign err_word_cnt = err_word_cnt_q;
  assign err_bit_cnt  = err_bit_cnt_q;
  assign word_cnt     = word_cnt_q;

endmodule
